// File: rtl/hgcal_inq_pkg.sv
// Shared constants, state encoding and the threshold quantizer for hgcal_input_quantizer.
package hgcal_inq_pkg;

    localparam int unsigned Q_W  = 2;
    localparam int unsigned QX_W = 32;

    localparam logic signed [15:0] T0_DEF = -16'sd8192;
    localparam logic signed [15:0] T1_DEF = 16'sd0;
    localparam logic signed [15:0] T2_DEF = 16'sd8192;

    typedef enum logic {
        FILL    = 1'b0,
        DISCARD = 1'b1
    } state_e;

    // Map a signed sample onto a 2-bit code against three ascending thresholds.
    function automatic logic [Q_W-1:0] quantize(
        input logic signed [QX_W-1:0] x,
        input logic signed [QX_W-1:0] t0,
        input logic signed [QX_W-1:0] t1,
        input logic signed [QX_W-1:0] t2
    );
        logic [Q_W-1:0] code;
        if (x >= t2) begin
            code = 2'd3;
        end else if (x >= t1) begin
            code = 2'd2;
        end else if (x >= t0) begin
            code = 2'd1;
        end else begin
            code = 2'd0;
        end
        return code;
    endfunction

endpackage

// File: rtl/hgcal_inq_framebuf.sv
// Two-entry frame buffer: one entry fills while the other waits on the consumer.
module hgcal_inq_framebuf
    import hgcal_inq_pkg::*;
#(
    parameter int unsigned NUM_FEATURES = 48,
    parameter int unsigned IDX_W        = $clog2(NUM_FEATURES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [Q_W-1:0]                wr_code,
    input  logic                          commit,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [NUM_FEATURES*Q_W-1:0]   rd_data,
    output logic                          buf_full
);

    localparam int unsigned FRAME_W = NUM_FEATURES * Q_W;

    logic [FRAME_W-1:0] buf_q [2];
    logic [FRAME_W-1:0] buf_d [2];
    logic               wr_sel_q, wr_sel_d;
    logic               rd_sel_q, rd_sel_d;
    logic [1:0]         full_cnt_q, full_cnt_d;
    logic               rd_fire;

    assign rd_fire  = rd_valid & rd_ready;
    assign rd_valid = (full_cnt_q != 2'd0);
    assign buf_full = (full_cnt_q == 2'd2);
    assign rd_data  = buf_q[rd_sel_q];

    // Write codes into the fill entry; commit and read each flip their own select.
    always_comb begin
        buf_d[0]   = buf_q[0];
        buf_d[1]   = buf_q[1];
        wr_sel_d   = wr_sel_q ^ commit;
        rd_sel_d   = rd_sel_q ^ rd_fire;
        full_cnt_d = full_cnt_q;
        if (wr_en) begin
            buf_d[wr_sel_q][wr_idx*Q_W +: Q_W] = wr_code;
        end
        unique case ({commit, rd_fire})
            2'b10:   full_cnt_d = 2'(full_cnt_q + 2'd1);
            2'b01:   full_cnt_d = 2'(full_cnt_q - 2'd1);
            default: full_cnt_d = full_cnt_q;
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            full_cnt_q <= 2'd0;
        end else begin
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            full_cnt_q <= full_cnt_d;
        end
    end

endmodule

// File: rtl/hgcal_input_quantizer.sv
// Sample quantizer and frame assembler feeding the HGCAL layer-0 LUT array.
// Optional HGCAL_INQ_STATS_EN adds frame_cnt / drop_cnt statistics outputs.
module hgcal_input_quantizer
    import hgcal_inq_pkg::*;
#(
    parameter int unsigned             NUM_FEATURES = 48,
    parameter int unsigned             IN_W         = 16,
    parameter int unsigned             Q_W          = 2,
    parameter logic signed [IN_W-1:0]  T0           = T0_DEF,
    parameter logic signed [IN_W-1:0]  T1           = T1_DEF,
    parameter logic signed [IN_W-1:0]  T2           = T2_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [IN_W-1:0]        s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [NUM_FEATURES*Q_W-1:0]   m_data,
    output logic                          err_frame
`ifdef HGCAL_INQ_STATS_EN
    ,
    output logic [15:0]                   frame_cnt,
    output logic [15:0]                   drop_cnt
`endif
);

    if (Q_W != 2) begin : g_qw_check
        $error("hgcal_input_quantizer: Q_W must be 2");
    end

    if (!((T0 < T1) && (T1 < T2))) begin : g_thr_check
        $error("hgcal_input_quantizer: thresholds must satisfy T0 < T1 < T2");
    end

    localparam int unsigned      IDX_W    = $clog2(NUM_FEATURES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEATURES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             wr_en, commit, accept, buf_full;
    logic [1:0]       code;

    assign code      = quantize(QX_W'(s_data), QX_W'(T0), QX_W'(T1), QX_W'(T2));
    assign s_ready   = (state_q == DISCARD) || !buf_full;
    assign accept    = s_valid & s_ready;
    assign err_frame = err_q;

    // Framing FSM: track the feature index and drop short or long frames.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (s_last) begin
                            commit = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end
                    end else if (s_last) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DISCARD: begin
                if (accept && s_last) begin
                    state_d = FILL;
                    idx_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // FSM and error-pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    hgcal_inq_framebuf #(
        .NUM_FEATURES (NUM_FEATURES),
        .IDX_W        (IDX_W)
    ) u_framebuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_idx   (idx_q),
        .wr_code  (code),
        .commit   (commit),
        .rd_valid (m_valid),
        .rd_ready (m_ready),
        .rd_data  (m_data),
        .buf_full (buf_full)
    );

`ifdef HGCAL_INQ_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Wrapping counters of delivered and dropped frames.
    always_comb begin
        frame_cnt_d = frame_cnt_q + {15'd0, (m_valid & m_ready)};
        drop_cnt_d  = drop_cnt_q + {15'd0, err_d};
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Scoreboard bench for hgcal_input_quantizer: stimulus pushes expected frames, a monitor pops and compares.
module tb_hgcal_input_quantizer;
    import hgcal_inq_pkg::*;

    localparam int N  = 48;
    localparam int FW = 96;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_last  = 1'b0;
    logic              m_ready = 1'b0;
    logic signed [15:0] s_data = 16'sd0;
    logic              s_ready, m_valid, err_frame;
    logic [FW-1:0]     m_data;
`ifdef HGCAL_INQ_STATS_EN
    logic [15:0]       frame_cnt, drop_cnt;
`endif

    hgcal_input_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .err_frame (err_frame)
`ifdef HGCAL_INQ_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;
    int popped   = 0;
    int stalls   = 0;
    logic [FW-1:0] exp_q [$];

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic signed [15:0] sample_val(input int pat, input int k);
        logic signed [15:0] v;
        int t;
        case (pat)
            0: case (k % 4)
                   0: v = -16'sd20000;
                   1: v = -16'sd8192;
                   2: v = 16'sd0;
                   default: v = 16'sd8192;
               endcase
            1: case (k % 8)
                   0: v = -16'sd8193;
                   1: v = -16'sd8192;
                   2: v = -16'sd1;
                   3: v = 16'sd0;
                   4: v = 16'sd8191;
                   5: v = 16'sd8192;
                   6: v = 16'sd32767;
                   default: v = -16'sd32768;
               endcase
            2: begin
                t = k * 1300 - 30000;
                v = 16'(t);
            end
            default: v = 16'sd8192;
        endcase
        return v;
    endfunction

    function automatic logic [FW-1:0] exp_frame(input int pat);
        logic [FW-1:0] f;
        case (pat)
            0: f = 96'hE4E4E4E4E4E4E4E4E4E4E4E4;
            1: f = 96'h3E943E943E943E943E943E94;
            2: begin
                f = '0;
                for (int k = 0; k < N; k++) begin
                    f[k*2 +: 2] = quantize(32'(sample_val(2, k)), 32'(T0_DEF), 32'(T1_DEF), 32'(T2_DEF));
                end
            end
            default: f = '1;
        endcase
        return f;
    endfunction

    task automatic send_sample(input logic signed [15:0] d, input logic last);
        logic ok;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        ok      = 1'b0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual s_ready stuck low required accept within 1000 cycles");
        end
    endtask

    task automatic send_frame(input int pat, input int len);
        if (len == N) exp_q.push_back(exp_frame(pat));
        for (int k = 0; k < len; k++) begin
            send_sample(sample_val(pat, k), (k == len - 1));
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pop the scoreboard on every output handshake and count error pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && !s_ready) stalls++;
            if (err_frame) err_seen++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: actual %h required no frame", m_data);
                end else begin
                    check("frame_data", m_data, exp_q.pop_front());
                end
                popped++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_s_ready", FW'(s_ready), FW'(1));
        check("reset_m_valid", FW'(m_valid), FW'(0));
        check("reset_err", FW'(err_frame), FW'(0));
        check("reset_m_data", m_data, '0);
        rst_n = 1'b1;

        // Single frame, cyclic pattern, check valid latency.
        m_ready = 1'b1;
        exp_q.push_back(exp_frame(0));
        for (int k = 0; k < N - 1; k++) send_sample(sample_val(0, k), 1'b0);
        check("t1_no_early_valid", FW'(m_valid), FW'(0));
        send_sample(sample_val(0, N - 1), 1'b1);
        check("t1_valid_after_last", FW'(m_valid), FW'(1));
        idle(3);
        check("t1_popped", FW'(popped), FW'(1));

        // Backpressure: two frames buffered, third waits.
        m_ready = 1'b0;
        send_frame(1, N);
        send_frame(2, N);
        check("t2_s_ready_low", FW'(s_ready), FW'(0));
        check("t2_m_valid", FW'(m_valid), FW'(1));
        check("t2_hold_data", m_data, exp_frame(1));
        fork
            send_frame(3, N);
            begin
                repeat (5) @(posedge clk);
                #1;
                check("t2_still_stalled", FW'(s_ready), FW'(0));
                m_ready = 1'b1;
            end
        join
        idle(5);
        check("t2_popped", FW'(popped), FW'(4));

        // Short frame dropped, next clean frame emitted.
        e0 = err_seen;
        send_frame(2, 10);
        check("t3_err_now", FW'(err_frame), FW'(1));
        idle(3);
        check("t3_err_count", FW'(err_seen - e0), FW'(1));
        check("t3_no_frame", FW'(popped), FW'(4));
        send_frame(0, N);
        idle(3);
        check("t3_clean_popped", FW'(popped), FW'(5));

        // Long frame: 53 samples consumed, one error, nothing emitted.
        e0 = err_seen;
        send_frame(1, 53);
        idle(3);
        check("t4_err_count", FW'(err_seen - e0), FW'(1));
        check("t4_no_frame", FW'(popped), FW'(5));
        send_frame(3, N);
        idle(3);
        check("t4_clean_popped", FW'(popped), FW'(6));

        // Ten back-to-back frames with the consumer always ready.
        stalls = 0;
        for (int f = 0; f < 10; f++) send_frame(f % 4, N);
        idle(3);
        check("t5_no_stall", FW'(stalls), FW'(0));
        check("t5_popped", FW'(popped), FW'(16));
`ifdef HGCAL_INQ_STATS_EN
        check("t5_frame_cnt", FW'(frame_cnt), FW'(16));
        check("t5_drop_cnt", FW'(drop_cnt), FW'(2));
`endif

        // Reset mid-frame with one buffer full.
        m_ready = 1'b0;
        send_frame(2, N);
        for (int k = 0; k < 20; k++) send_sample(sample_val(0, k), 1'b0);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        check("t6_m_valid", FW'(m_valid), FW'(0));
        check("t6_s_ready", FW'(s_ready), FW'(1));
        check("t6_err", FW'(err_frame), FW'(0));
        check("t6_m_data", m_data, '0);
`ifdef HGCAL_INQ_STATS_EN
        check("t6_frame_cnt", FW'(frame_cnt), FW'(0));
        check("t6_drop_cnt", FW'(drop_cnt), FW'(0));
`endif
        exp_q.delete();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        send_frame(1, N);
        idle(3);
        check("t6_recover_popped", FW'(popped), FW'(17));
        check("t6_queue_empty", FW'(exp_q.size()), FW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
